ifetch_responder: RTL

Instruction-memory responder on the instruction fetch bus: the target end of the request/response handshake issued by the prefetch unit. It accepts word fetch requests and reads a local synchronous word memory over a fixed-latency pipeline. Responses return strictly in request order through a response queue that absorbs back-pressure. Out-of-range, misaligned and reserved-privilege fetches are flagged on the read-error line. A loader write port lets the testbench or boot logic fill the memory.

---
 rtl/ifetch_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_responder.sv
// ifetch_responder
// Target end of the instruction-fetch request/response handshake. Accepts
// word fetches from the prefetch unit, reads a local synchronous word memory
// through a fixed-latency pipeline, and returns responses strictly in
// acceptance order through a small response queue that absorbs back-pressure.
// Misaligned, out-of-range and reserved-privilege fetches come back with
// irsprerr_o set and zero data. A loader port fills the memory.
//
// Ports:
//   clk_i, reset_i      clock (rising edge), synchronous active-high reset
//   clk_en_i            global clock enable; all state frozen while low
//   ireqready_o         request can be accepted this cycle
//   ireqvalid_i         request valid
//   ireqhpl_i           requesting HART privilege level (2'b10 is reserved)
//   ireqaddr_i          fetch byte address
//   irspready_i         initiator accepts the response
//   irspvalid_o         response valid (queue not empty)
//   irsprerr_o          response is an error
//   irspdata_o          fetched word, zero on error or when no response
//   memwr_i             loader write strobe
//   memwaddr_i          loader word index
//   memwdata_i          loader write data
module ifetch_responder #(
  parameter int C_BUS_SZX = 5,
  localparam int C_BUS_SZ = 2**C_BUS_SZX,
  parameter int C_MEM_DEPTH_X = 10,
  parameter logic [C_BUS_SZ-1:0] C_BASE_ADDR = '0,
  parameter int C_READ_LATENCY = 2,
  parameter int C_RSP_DEPTH_X = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  output logic                     ireqready_o,
  input  logic                     ireqvalid_i,
  input  logic [1:0]               ireqhpl_i,
  input  logic [C_BUS_SZ-1:0]      ireqaddr_i,
  input  logic                     irspready_i,
  output logic                     irspvalid_o,
  output logic                     irsprerr_o,
  output logic [C_BUS_SZ-1:0]      irspdata_o,
  input  logic                     memwr_i,
  input  logic [C_MEM_DEPTH_X-1:0] memwaddr_i,
  input  logic [C_BUS_SZ-1:0]      memwdata_i
);

  localparam int C_MEM_WORDS = 2**C_MEM_DEPTH_X;
  localparam int C_RSP_DEPTH = 2**C_RSP_DEPTH_X;
  localparam logic [C_RSP_DEPTH_X:0] C_RSP_LIMIT = (C_RSP_DEPTH_X+1)'(C_RSP_DEPTH);

  logic [C_BUS_SZ-1:0]      mem [C_MEM_WORDS];

  logic                     acc;
  logic                     rsp;
  logic                     in_range;
  logic                     req_err;
  logic [C_MEM_DEPTH_X-1:0] req_idx;

  logic [C_RSP_DEPTH_X:0]   outstanding;

  logic                     push_valid;
  logic                     push_err;
  logic [C_BUS_SZ-1:0]      push_data;

  logic                     q_err  [C_RSP_DEPTH];
  logic [C_BUS_SZ-1:0]      q_data [C_RSP_DEPTH];
  logic [C_RSP_DEPTH_X-1:0] wr_ptr;
  logic [C_RSP_DEPTH_X-1:0] rd_ptr;
  logic [C_RSP_DEPTH_X:0]   q_count;
  logic                     q_valid;

  // Ready only depends on how many fetches are in flight or queued, so a pop
  // in the same cycle as a full counter does not open the door until later.
  assign ireqready_o = clk_en_i & (outstanding < C_RSP_LIMIT);
  assign acc         = clk_en_i & ireqvalid_i & ireqready_o;

  assign q_valid     = (q_count != '0);
  assign rsp         = clk_en_i & q_valid & irspready_i;
  assign irspvalid_o = q_valid;
  assign irsprerr_o  = q_valid & q_err[rd_ptr];
  assign irspdata_o  = q_valid ? q_data[rd_ptr] : '0;

  // The memory is aligned to its own size, so being in range means the
  // address bits above the word index match the base address.
  assign req_idx  = ireqaddr_i[C_MEM_DEPTH_X+1:2];
  assign in_range = (ireqaddr_i[C_BUS_SZ-1:C_MEM_DEPTH_X+2] ==
                     C_BASE_ADDR[C_BUS_SZ-1:C_MEM_DEPTH_X+2]);
  assign req_err  = (ireqaddr_i[1:0] != 2'b00) | ~in_range | (ireqhpl_i == 2'b10);

  // Loader write port; the memory is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && memwr_i) begin
      mem[memwaddr_i] <= memwdata_i;
    end
  end

  // Count of accepted fetches whose responses have not been handed over yet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding <= '0;
    end else if (clk_en_i) begin
      case ({acc, rsp})
        2'b10:   outstanding <= outstanding + (C_RSP_DEPTH_X+1)'(1);
        2'b01:   outstanding <= outstanding - (C_RSP_DEPTH_X+1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  generate
    if (C_READ_LATENCY == 1) begin : g_direct
      // With single-cycle latency the queue entry itself is the read register.
      assign push_valid = acc;
      assign push_err   = req_err;
      assign push_data  = mem[req_idx];
    end else begin : g_pipe
      localparam int N = C_READ_LATENCY - 1;

      logic                pipe_valid [N];
      logic                pipe_err   [N];
      logic [C_BUS_SZ-1:0] pipe_data  [N];

      // Valid/error shift; stage 0 is loaded at acceptance.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < N; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_err[i]   <= 1'b0;
          end
        end else if (clk_en_i) begin
          pipe_valid[0] <= acc;
          pipe_err[0]   <= req_err;
          for (int i = 1; i < N; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
          end
        end
      end

      // Registered memory read in stage 0, skipped for erroring fetches;
      // reads see the word as it was before a same-cycle loader write.
      always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
          if (acc && !req_err) begin
            pipe_data[0] <= mem[req_idx];
          end
          for (int i = 1; i < N; i++) begin
            pipe_data[i] <= pipe_data[i-1];
          end
        end
      end

      assign push_valid = pipe_valid[N-1];
      assign push_err   = pipe_err[N-1];
      assign push_data  = pipe_data[N-1];
    end
  endgenerate

  // Response queue control. It cannot overflow because the outstanding
  // counter never lets more fetches in than the queue has entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (clk_en_i) begin
      if (push_valid) begin
        wr_ptr <= wr_ptr + C_RSP_DEPTH_X'(1);
      end
      if (rsp) begin
        rd_ptr <= rd_ptr + C_RSP_DEPTH_X'(1);
      end
      case ({push_valid, rsp})
        2'b10:   q_count <= q_count + (C_RSP_DEPTH_X+1)'(1);
        2'b01:   q_count <= q_count - (C_RSP_DEPTH_X+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Response queue storage; error entries always carry zero data.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && push_valid) begin
      q_err[wr_ptr]  <= push_err;
      q_data[wr_ptr] <= push_err ? '0 : push_data;
    end
  end

endmodule
